riscv_mem_arbiter: RTL
======================

// Module: riscv_mem_arbiter
// PURPOSE
//  Shares the core's single AXI4-lite master port between two requesters:
//  instruction fetch (read-only) and data load/store. It owns all AXI
//  valid/ready sequencing, so requesters use a simple req/ack handshake.
//  It sits between the core state machine and the memory fabric.
// PARAMETERS
//  DATA_RUN_MAX  4       consecutive data grants allowed while i_req waits
//  INST_PROT     3'b101  arprot driven for instruction fetches
//  DATA_PROT     3'b000  arprot/awprot driven for data accesses
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   asynchronous, active-low reset
//  i_req      in   1   fetch request; held, with i_addr stable, until i_ack
//  i_addr     in   32  fetch address
//  i_ack      out  1   one-cycle completion pulse for the fetch
//  i_rdata    out  32  fetched word; valid while i_ack=1
//  i_err      out  1   fetch failed (rresp[1]=1); valid while i_ack=1
//  d_req      in   1   data request; held, with d_* stable, until d_ack
//  d_we       in   1   1=store, 0=load
//  d_addr     in   32  data address
//  d_wdata    in   32  store data
//  d_wstrb    in   4   store byte strobes
//  d_ack      out  1   one-cycle completion pulse for the data access
//  d_rdata    out  32  load word; valid while d_ack=1
//  d_err      out  1   access failed (rresp/bresp[1]=1); valid while d_ack=1
//  arvalid/arready/araddr[32]/arprot[3]            AXI AR channel (master side)
//  rvalid/rready/rdata[32]/rresp[2]                AXI R channel
//  awvalid/awready/awaddr[32]/awprot[3]            AXI AW channel
//  wvalid/wready/wdata[32]/wstrb[4]                AXI W channel
//  bvalid(in)/bready(out)/bresp[2]                 AXI B channel
// BEHAVIOUR
//  Reset values: all valid/ready outputs, acks, errs, rdata, addrs, wdata,
//  wstrb and run counter are 0; prot outputs are DATA_PROT; FSM is IDLE.
//  Reset asserted mid-transaction aborts immediately and issues no ack.
//  FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
//  IDLE arbitration (one cycle per decision):
//   - d_req only: grant data. i_req only: grant inst.
//   - both: grant data unless run_cnt==DATA_RUN_MAX, then grant inst.
//   - run_cnt: +1 on each data grant while i_req=1; cleared on inst grant
//     and on any data grant with i_req=0; saturates at DATA_RUN_MAX.
//  A grant latches the address/data/prot and owner into registers.
//   Read (inst, or data with d_we=0): arvalid=1 -> RD_ADDR.
//   Write: awvalid=1 and wvalid=1 in the same cycle -> WR_REQ.
//  RD_ADDR: hold arvalid until arvalid&&arready; then arvalid=0, rready=1 -> RD_DATA.
//  RD_DATA: on rvalid&&rready capture rdata and err=rresp[1]; rready=0 -> DONE.
//  WR_REQ: awvalid and wvalid each drop independently after their own
//   handshake; once both are done, bready=1 -> WR_RESP. A same-cycle double
//   handshake goes straight to WR_RESP.
//  WR_RESP: on bvalid&&bready capture err=bresp[1]; bready=0 -> DONE.
//  DONE: pulse the owner's ack for exactly one cycle with rdata/err -> IDLE.
//  The non-owner's ack stays 0. One transaction is outstanding at most.
//  Best-case latency from req to ack is 4 cycles (AR/AW and R/B ready at once).
//  AXI outputs (addr, data, strb, prot) are stable while their valid is high.
//  rresp/bresp 00 or 01 mean OK; 10 or 11 mean err=1.
//  d_req with d_we=1 never touches AR; i_req never touches AW/W.
// TESTING
//  1 i_req, addr 0x100; slave returns 0x00000013 with OKAY ->
//    i_ack pulses once, i_rdata=0x13, i_err=0, arprot=101 on AR.
//  2 d_req store, addr 0x200, data 0xDEADBEEF, wstrb 0011; awready 2 cycles
//    before wready -> awvalid drops first; d_ack after B; wstrb=0011.
//  3 i_req and d_req held together for 10 transactions, DATA_RUN_MAX=4 ->
//    grant order D,D,D,D,I,D,...; no requester starves.
//  4 load whose rresp=2'b10 -> d_ack=1 and d_err=1; next fetch completes normally.
//  5 reset low while in RD_DATA -> all outputs reset in the same cycle;
//    no ack; a fresh request after reset completes.
//  6 arready held low for 20 cycles -> arvalid and araddr stay stable throughout.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Shares the core's single AXI4-lite master port between instruction fetch
//   (read-only) and data load/store. Requesters use a req/ack handshake; this
//   block owns all AXI valid/ready sequencing and keeps at most one
//   transaction outstanding.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   i_req/i_addr                fetch request, held with address until i_ack
//   i_ack/i_rdata/i_err         one-cycle fetch completion with data/error
//   d_req/d_we/d_addr/d_wdata/d_wstrb
//                               data request (d_we=1 store), held until d_ack
//   d_ack/d_rdata/d_err         one-cycle data completion with data/error
//   ar*/r*/aw*/w*/b*            AXI4-lite master channels
module riscv_mem_arbiter #(
  parameter int unsigned DATA_RUN_MAX = 4,
  parameter logic [2:0]  INST_PROT    = 3'b101,
  parameter logic [2:0]  DATA_PROT    = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp
);

  localparam int unsigned CW = $clog2(DATA_RUN_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t          state_q, state_n;
  logic            owner_inst_q, owner_inst_n;
  logic [31:0]     addr_q, addr_n;
  logic [31:0]     wdata_q, wdata_n;
  logic [3:0]      wstrb_q, wstrb_n;
  logic [2:0]      prot_q, prot_n;
  logic            arvalid_q, arvalid_n;
  logic            awvalid_q, awvalid_n;
  logic            wvalid_q, wvalid_n;
  logic            rready_q, rready_n;
  logic            bready_q, bready_n;
  logic [31:0]     rdata_q, rdata_n;
  logic            err_q, err_n;
  logic [CW-1:0]   run_cnt_q, run_cnt_n;
  logic            run_at_max;

  // OKAY and EXOKAY are both reported as success, so only resp[1] matters.
  logic unused_resp_lsb;
  assign unused_resp_lsb = ^{rresp[0], bresp[0]};

  assign run_at_max = (run_cnt_q == CW'(DATA_RUN_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_inst_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      prot_q       <= DATA_PROT;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      rready_q     <= 1'b0;
      bready_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      run_cnt_q    <= '0;
    end else begin
      state_q      <= state_n;
      owner_inst_q <= owner_inst_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      wstrb_q      <= wstrb_n;
      prot_q       <= prot_n;
      arvalid_q    <= arvalid_n;
      awvalid_q    <= awvalid_n;
      wvalid_q     <= wvalid_n;
      rready_q     <= rready_n;
      bready_q     <= bready_n;
      rdata_q      <= rdata_n;
      err_q        <= err_n;
      run_cnt_q    <= run_cnt_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    owner_inst_n = owner_inst_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    wstrb_n      = wstrb_q;
    prot_n       = prot_q;
    arvalid_n    = arvalid_q;
    awvalid_n    = awvalid_q;
    wvalid_n     = wvalid_q;
    rready_n     = rready_q;
    bready_n     = bready_q;
    rdata_n      = rdata_q;
    err_n        = err_q;
    run_cnt_n    = run_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (d_req && !(i_req && run_at_max)) begin
          owner_inst_n = 1'b0;
          addr_n       = d_addr;
          prot_n       = DATA_PROT;
          // The guard above means the counter is below its limit whenever a
          // fetch is waiting, so the increment cannot overflow the cap.
          run_cnt_n    = i_req ? run_cnt_q + CW'(1) : '0;
          if (d_we) begin
            wdata_n   = d_wdata;
            wstrb_n   = d_wstrb;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR_REQ;
          end else begin
            arvalid_n = 1'b1;
            state_n   = RD_ADDR;
          end
        end else if (i_req) begin
          owner_inst_n = 1'b1;
          addr_n       = i_addr;
          prot_n       = INST_PROT;
          run_cnt_n    = '0;
          arvalid_n    = 1'b1;
          state_n      = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rdata_n  = rdata;
          err_n    = rresp[1];
          rready_n = 1'b0;
          state_n  = DONE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; a channel whose valid already
        // dropped counts as done.
        if (awready) awvalid_n = 1'b0;
        if (wready)  wvalid_n  = 1'b0;
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          err_n    = bresp[1];
          bready_n = 1'b0;
          state_n  = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign i_ack   = (state_q == DONE) && owner_inst_q;
  assign d_ack   = (state_q == DONE) && !owner_inst_q;
  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;
  assign i_err   = err_q;
  assign d_err   = err_q;

  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arprot  = prot_q;
  assign rready  = rready_q;
  assign awvalid = awvalid_q;
  assign awaddr  = addr_q;
  assign awprot  = prot_q;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bready  = bready_q;

endmodule
